// File: rtl/fifo_rd_stream_pkg.sv
// Shared defaults and helpers for the async_fifo read-side drain stage.
// WIDTH/BURST defaults here must track the async_fifo instance they pair with.
package fifo_rd_stream_pkg;

   localparam int FIFO_WIDTH_DEF = 8;
   localparam int FIFO_BURST_DEF = 4;
   localparam int SKID_DEPTH     = 3;

   typedef logic [1:0] occ_t;

   // Beat counter needs at least one bit even for single-word frames.
   function automatic int beat_width(input int burst);
      return (burst > 1) ? $clog2(burst) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Three-entry register FIFO absorbing words already committed out of async_fifo.
// Circular pointers keep the head entry stationary while the consumer stalls.
module rd_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF
) (
   input  logic             rd_clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output occ_t             occ,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem [SKID_DEPTH];
   occ_t             rd_ptr;
   occ_t             wr_ptr;

   function automatic occ_t ptr_next(input occ_t p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

   // The upstream credit check must make an overflowing push impossible.
   a_no_overflow : assert property (@(posedge rd_clk) disable iff (!rst_n)
      !(push && !pop && (occ == 2'd3)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains async_fifo into a valid/ready stream with frame marking every BURST words.
// Reads are credit-gated on local buffer space so no word is ever dropped.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int BURST = FIFO_BURST_DEF
) (
   input  logic             rd_clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [15:0]      frame_cnt
);

   localparam int            BW        = beat_width(BURST);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

   logic          pending;
   occ_t          occ;
   logic          pop;
   logic          credit_ok;
   logic [BW-1:0] beat;

   // Words in flight from the FIFO count against space just like stored ones.
   assign credit_ok  = (({1'b0, occ} + {2'b00, pending}) < 3'(SKID_DEPTH));
   assign fifo_rd_en = !fifo_empty && credit_ok && rst_n;

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) pending <= 1'b0;
      else        pending <= fifo_rd_en && !fifo_empty;
   end

   rd_skid_buf #(.WIDTH(WIDTH)) u_skid (
      .rd_clk    (rd_clk),
      .rst_n     (rst_n),
      .push      (pending),
      .push_data (fifo_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (m_data)
   );

   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid && m_ready;
   assign m_last  = m_valid && (beat == BEAT_LAST);

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         beat      <= '0;
         frame_cnt <= '0;
      end else if (pop) begin
         if (beat == BEAT_LAST) begin
            beat      <= '0;
            frame_cnt <= frame_cnt + 16'd1;
         end else begin
            beat      <= beat + 1'b1;
         end
      end
   end

endmodule
